// File: rtl/sprite_linebuf_scanout_pkg.sv
// Shared types and sizes for the sprite line-buffer scanout block.
package slap_spr_pkg;

    localparam int LB_AW    = 9;
    localparam int LB_DW    = 8;
    localparam int LB_DEPTH = 2 ** LB_AW;

    // Line-buffer storage format: pixel index in the upper nibble.
    typedef struct packed {
        logic [3:0] pix;
        logic [3:0] colsel;
    } lb_pix_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sprite_linebuf_scanout_if.sv
// Renderer write port plus scanout controls/outputs of the sprite line buffer.
interface sprite_linebuf_scanout_if;
    import slap_spr_pkg::*;

    logic             pix_ce;
    logic             line_start;
    logic             SCREEN_FLIP;
    logic [LB_AW-1:0] HPIX_LT;
    logic             wr_en;
    logic [LB_AW-1:0] wr_addr;
    lb_pix_t          wr_data;
    logic [7:0]       pixel_output;
    logic             pixel_valid;
    logic             bank_sel;
    logic             init_busy;

    modport master (
        output pix_ce, line_start, SCREEN_FLIP, HPIX_LT, wr_en, wr_addr, wr_data,
        input  pixel_output, pixel_valid, bank_sel, init_busy
    );

    modport slave (
        input  pix_ce, line_start, SCREEN_FLIP, HPIX_LT, wr_en, wr_addr, wr_data,
        output pixel_output, pixel_valid, bank_sel, init_busy
    );

endinterface

// File: rtl/sprite_linebuf_scanout_lb_bank.sv
// One line-buffer bank: single write port, registered read, no reset on storage.
module lb_bank
    import slap_spr_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [LB_AW-1:0] waddr,
    input  lb_pix_t          wdata,
    input  logic [LB_AW-1:0] raddr,
    output lb_pix_t          rdata
);

    lb_pix_t mem [LB_DEPTH];

    // Write port and read-first registered read.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sprite_linebuf_scanout.sv
// Ping-pong sprite line buffer read side: scans the display bank out on pix_ce
// and clears each pixel behind the read so the bank comes back blank.
module sprite_linebuf_scanout
    import slap_spr_pkg::*;
(
    input  logic                      master_clk,
    input  logic                      reset,
    sprite_linebuf_scanout_if.slave   bus
);

    state_t            state, state_nxt;
    logic [LB_AW-1:0]  init_cnt;
    logic              bank_sel;
    logic              run;
    logic              cur_disp;
    logic [LB_AW-1:0]  ra;
    logic              rnd_we, rnd_bank;
    logic              clr_pend, clr_bank, clr_hit, clr_go, clr_drop;
    logic [LB_AW-1:0]  clr_addr;
    logic              rd_pend;
    lb_pix_t           q_hold;
    logic [7:0]        pix_out;
    logic              pix_vld;

    logic [1:0]              bk_we;
    logic [1:0][LB_AW-1:0]   bk_wa;
    lb_pix_t [1:0]           bk_wd;
    lb_pix_t [1:0]           bk_q;

    assign run      = (state == ST_RUN);
    // A swap on the same clock as pix_ce already reads the new display bank.
    assign cur_disp = bank_sel ^ (run & bus.line_start);
    assign ra       = bus.SCREEN_FLIP ? ~bus.HPIX_LT : bus.HPIX_LT;
    // Zero pixel index means transparent: never stored.
    assign rnd_we   = run & bus.wr_en & (bus.wr_data.pix != 4'd0);
    assign rnd_bank = ~cur_disp;

    // The pending clear can only share a bank with the renderer right after a
    // swap. Renderer owns the port then; same address drops the clear, a
    // different address leaves it pending for the next free clock.
    assign clr_hit  = clr_pend & rnd_we & (rnd_bank == clr_bank);
    assign clr_go   = clr_pend & ~clr_hit;
    assign clr_drop = clr_hit & (bus.wr_addr == clr_addr);

    assign bus.pixel_output = pix_out;
    assign bus.pixel_valid  = pix_vld;
    assign bus.bank_sel     = bank_sel;
    assign bus.init_busy    = (state == ST_INIT);

    // FSM state register.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    // FSM next state: leave INIT after the last address has been cleared.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (&init_cnt) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    // Clear-sweep address counter and display-bank toggle.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            init_cnt <= '0;
            bank_sel <= 1'b0;
        end else begin
            if (!run)
                init_cnt <= init_cnt + LB_AW'(1);
            if (run && bus.line_start)
                bank_sel <= ~bank_sel;
        end
    end

    // Read tracking: latch the clear target, capture read data one clock
    // later, and present it on the following pix_ce.
    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            clr_pend <= 1'b0;
            clr_bank <= 1'b0;
            clr_addr <= '0;
            rd_pend  <= 1'b0;
            q_hold   <= '0;
            pix_out  <= '0;
            pix_vld  <= 1'b0;
        end else begin
            rd_pend <= run & bus.pix_ce;
            if (run && bus.pix_ce) begin
                clr_pend <= 1'b1;
                clr_bank <= cur_disp;
                clr_addr <= ra;
            end else if (clr_go || clr_drop) begin
                clr_pend <= 1'b0;
            end
            if (rd_pend)
                q_hold <= bk_q[clr_bank];
            if (run && bus.pix_ce) begin
                pix_out <= {q_hold.colsel, q_hold.pix};
                pix_vld <= (q_hold.pix != 4'd0);
            end
        end
    end

    // Bank write-port mux: sweep during INIT, else clear and renderer.
    always_comb begin
        bk_we = '0;
        bk_wa = '0;
        bk_wd = '0;
        if (!run) begin
            bk_we = 2'b11;
            bk_wa = {init_cnt, init_cnt};
        end else begin
            if (clr_go) begin
                bk_we[clr_bank] = 1'b1;
                bk_wa[clr_bank] = clr_addr;
            end
            if (rnd_we) begin
                bk_we[rnd_bank] = 1'b1;
                bk_wa[rnd_bank] = bus.wr_addr;
                bk_wd[rnd_bank] = bus.wr_data;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        lb_bank u_bank (
            .clk   (master_clk),
            .we    (bk_we[b]),
            .waddr (bk_wa[b]),
            .wdata (bk_wd[b]),
            .raddr (ra),
            .rdata (bk_q[b])
        );
    end

endmodule

// File: tb/tb_sprite_linebuf_scanout.sv
// Scoreboard bench for sprite_linebuf_scanout: a two-bank memory model
// predicts every scanned pixel; the prediction is queued at read time and
// compared when the next pix_ce presents it.
module tb_sprite_linebuf_scanout;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sprite_linebuf_scanout_if bus();

    sprite_linebuf_scanout dut (
        .master_clk (clk),
        .reset      (reset),
        .bus        (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] mem [2][512];
    logic       mbank;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        foreach (mem[b, a]) mem[b][a] = 8'h00;
        mbank = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'h00);
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        if (d[7:4] != 4'd0) mem[~mbank][a] = d;
    endtask

    task automatic swap(input string nm);
        bus.line_start = 1'b1;
        @(negedge clk);
        bus.line_start = 1'b0;
        mbank = ~mbank;
        n_chk++;
        if (bus.bank_sel !== mbank) begin
            n_fail++;
            $display("FAIL %s bank_sel: got %b want %b", nm, bus.bank_sel, mbank);
        end
    endtask

    // Pulse pix_ce; check the pixel presented (from the previous read) and
    // queue the prediction for this read.
    task automatic pix(input logic [8:0] a, input logic flip, input string nm, input bit tail = 1'b1);
        logic [7:0] e;
        logic [8:0] ra;
        bus.HPIX_LT = a; bus.SCREEN_FLIP = flip; bus.pix_ce = 1'b1;
        @(negedge clk);
        bus.pix_ce = 1'b0;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected pixel queued, got %h", nm, bus.pixel_output);
        end else begin
            e = exp_q.pop_front();
            if (bus.pixel_output !== {e[3:0], e[7:4]}) begin
                n_fail++;
                $display("FAIL %s pixel_output: got %h want %h", nm, bus.pixel_output, {e[3:0], e[7:4]});
            end
            n_chk++;
            if (bus.pixel_valid !== (e[7:4] != 4'd0)) begin
                n_fail++;
                $display("FAIL %s pixel_valid: got %b want %b", nm, bus.pixel_valid, (e[7:4] != 4'd0));
            end
        end
        ra = flip ? ~a : a;
        exp_q.push_back(mem[mbank][ra]);
        mem[mbank][ra] = 8'h00;
        if (tail) @(negedge clk);
    endtask

    // Count the sweep while throwing ignored traffic at the block.
    task automatic check_init(input string nm);
        int busy = 0;
        bit bad  = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!bus.init_busy) break;
            busy++;
            if (bus.pixel_output !== 8'h00 || bus.bank_sel !== 1'b0 || bus.pixel_valid !== 1'b0) bad = 1'b1;
            bus.pix_ce     = (i % 3 == 0);
            bus.line_start = (i % 64 == 5);
            bus.wr_en      = 1'b1;
            bus.wr_addr    = 9'(i);
            bus.wr_data    = 8'hFF;
            @(negedge clk);
        end
        bus.pix_ce = 1'b0; bus.line_start = 1'b0; bus.wr_en = 1'b0;
        n_chk++;
        if (busy !== 512) begin
            n_fail++;
            $display("FAIL %s init_busy cycles: got %0d want 512", nm, busy);
        end
        n_chk++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s outputs during init: got nonzero want all zero", nm);
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        n_chk++;
        if (bus.pixel_output !== 8'h00) begin n_fail++; $display("FAIL reset pixel_output: got %h want 00", bus.pixel_output); end
        n_chk++;
        if (bus.init_busy !== 1'b1) begin n_fail++; $display("FAIL reset init_busy: got %b want 1", bus.init_busy); end
        n_chk++;
        if (bus.bank_sel !== 1'b0) begin n_fail++; $display("FAIL reset bank_sel: got %b want 0", bus.bank_sel); end
        reset = 1'b0;
        check_init("init");
    endtask

    task automatic test_basic();
        wr(9'h010, 8'h5A);
        swap("t2 swap");
        pix(9'h010, 1'b0, "t2 prev");
        pix(9'h011, 1'b0, "t2 read010");
        swap("t2 swap2");
        swap("t2 swap3");
        pix(9'h010, 1'b0, "t2 prev2");
        pix(9'h012, 1'b0, "t2 cleared010");
    endtask

    task automatic test_transparent();
        wr(9'h020, 8'h3C);
        wr(9'h020, 8'h07);
        swap("t3 swap");
        pix(9'h020, 1'b0, "t3 prev");
        pix(9'h021, 1'b0, "t3 read020");
    endtask

    task automatic test_flip();
        wr(9'h000, 8'h12);
        swap("t4 swap");
        pix(9'h1FF, 1'b1, "t4 prev");
        pix(9'h000, 1'b1, "t4 flip1ff");
        pix(9'h000, 1'b0, "t4 flip000");
    endtask

    task automatic test_collision();
        wr(9'h040, 8'h77);
        swap("t5 swap");
        pix(9'h040, 1'b0, "t5 prev", 1'b0);
        // Clear cycle of that read: swap and renderer write to the same address.
        bus.line_start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 9'h040; bus.wr_data = 8'h9F;
        @(negedge clk);
        bus.line_start = 1'b0; bus.wr_en = 1'b0;
        mbank = ~mbank;
        mem[~mbank][9'h040] = 8'h9F;
        @(negedge clk);
        swap("t5 swapback");
        pix(9'h040, 1'b0, "t5 read040old");
        pix(9'h041, 1'b0, "t5 write_wins");
    endtask

    task automatic test_back_to_back();
        logic [8:0] a;
        for (int i = 0; i < 12; i++) wr(9'h100 + 9'(i * 5), 8'($urandom));
        wr(9'h100, 8'hE1);
        swap("b2b swap");
        for (int i = 0; i < 12; i++) begin
            a = 9'h100 + 9'(i * 5);
            pix(a, 1'b0, "b2b scan");
        end
        pix(9'h1F0, 1'b0, "b2b last");
    endtask

    task automatic test_reset_mid();
        wr(9'h080, 8'h4B);
        swap("t6 swap");
        pix(9'h080, 1'b0, "t6 prev");
        pix(9'h081, 1'b0, "t6 read080");
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (bus.pixel_output !== 8'h00) begin n_fail++; $display("FAIL t6 async pixel_output: got %h want 00", bus.pixel_output); end
        n_chk++;
        if (bus.pixel_valid !== 1'b0) begin n_fail++; $display("FAIL t6 async pixel_valid: got %b want 0", bus.pixel_valid); end
        n_chk++;
        if (bus.bank_sel !== 1'b0) begin n_fail++; $display("FAIL t6 async bank_sel: got %b want 0", bus.bank_sel); end
        n_chk++;
        if (bus.init_busy !== 1'b1) begin n_fail++; $display("FAIL t6 async init_busy: got %b want 1", bus.init_busy); end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_init("t6 reinit");
        pix(9'h080, 1'b0, "t6 post prev");
        pix(9'h081, 1'b0, "t6 bankA080");
        swap("t6 swap2");
        pix(9'h080, 1'b0, "t6 post prev2");
        pix(9'h010, 1'b0, "t6 bankB080");
        pix(9'h011, 1'b0, "t6 bankB010");
    endtask

    initial begin
        bus.pix_ce = 1'b0; bus.line_start = 1'b0; bus.SCREEN_FLIP = 1'b0;
        bus.HPIX_LT = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        test_reset();
        test_basic();
        test_transparent();
        test_flip();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
